// File: rtl/cmd_issue.sv
// Single-request DRAM command issuer: tracks open rows per {bg,ba} and sequences
// PRE/ACT/CAS with tRP, tRCD and a conservative global tRAS window.
module cmd_issue #(
  parameter int INDEX_BITS = 7,
  parameter int RA_BITS    = 16,
  parameter int CA_BITS    = 10,
  parameter int DATA_BITS  = 16,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 3,
  parameter int T_RAS      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [RA_BITS-1:0]    row_i,
  input  logic [CA_BITS-1:0]    col_i,
  input  logic [1:0]            ba_i,
  input  logic [1:0]            bg_i,
  output logic                  req_ready,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_o,
  output logic [RA_BITS-1:0]    cmd_row,
  output logic [CA_BITS-1:0]    cmd_col,
  output logic [1:0]            cmd_ba,
  output logic [1:0]            cmd_bg,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx
);
  localparam int TMAX = (T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                                        : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RAS_MAX = TW'(T_RAS);
  localparam logic [TW-1:0] RCD_LD  = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RP_LD   = TW'(T_RP - 1);

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_PRE = 3'd2, C_RD = 3'd3, C_WR = 3'd4;

  typedef enum logic [2:0] {IDLE, DECIDE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS} state_t;

  typedef struct packed {
    logic                  wr;
    logic [DATA_BITS-1:0]  data;
    logic [INDEX_BITS-1:0] idx;
    logic [RA_BITS-1:0]    row;
    logic [CA_BITS-1:0]    col;
    logic [1:0]            ba;
    logic [1:0]            bg;
  } req_t;

  state_t             state;
  req_t               hold;
  logic [15:0]        open_q;
  logic [RA_BITS-1:0] row_q [16];
  logic [TW-1:0]      ras_cnt;
  logic [TW-1:0]      timer;
  logic [3:0]         key;

  assign key       = {hold.bg, hold.ba};
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      open_q    <= '0;
      for (int i = 0; i < 16; i++) row_q[i] <= '0;
      ras_cnt   <= RAS_MAX;
      timer     <= '0;
      cmd_valid <= 1'b0;
      cmd_o     <= C_NOP;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cmd_ba    <= '0;
      cmd_bg    <= '0;
      cmd_data  <= '0;
      cmd_idx   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_o     <= C_NOP;
      if (ras_cnt < RAS_MAX) ras_cnt <= ras_cnt + 1'b1;
      case (state)
        IDLE: if (req_valid) begin
          hold  <= '{wr: req_wr, data: data_i, idx: idx_i, row: row_i,
                     col: col_i, ba: ba_i, bg: bg_i};
          state <= DECIDE;
        end
        DECIDE: begin
          if (!open_q[key])                state <= ACT;
          else if (row_q[key] == hold.row) state <= CAS;
          else                             state <= PRE;
        end
        PRE: if (ras_cnt >= RAS_MAX) begin
          cmd_valid   <= 1'b1;
          cmd_o       <= C_PRE;
          cmd_ba      <= hold.ba;
          cmd_bg      <= hold.bg;
          open_q[key] <= 1'b0;
          timer       <= RP_LD;
          // a one-cycle tRP has no wait state to pass through
          state       <= (T_RP == 1) ? ACT : WAIT_RP;
        end
        WAIT_RP: begin
          timer <= timer - 1'b1;
          if (timer == 1) state <= ACT;
        end
        ACT: begin
          cmd_valid   <= 1'b1;
          cmd_o       <= C_ACT;
          cmd_row     <= hold.row;
          cmd_ba      <= hold.ba;
          cmd_bg      <= hold.bg;
          open_q[key] <= 1'b1;
          row_q[key]  <= hold.row;
          ras_cnt     <= TW'(1);
          timer       <= RCD_LD;
          state       <= (T_RCD == 1) ? CAS : WAIT_RCD;
        end
        WAIT_RCD: begin
          timer <= timer - 1'b1;
          if (timer == 1) state <= CAS;
        end
        CAS: begin
          cmd_valid <= 1'b1;
          cmd_o     <= hold.wr ? C_WR : C_RD;
          cmd_col   <= hold.col;
          cmd_ba    <= hold.ba;
          cmd_bg    <= hold.bg;
          cmd_data  <= hold.data;
          cmd_idx   <= hold.idx;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_issue.sv
// Scoreboard bench for cmd_issue: a timing model predicts each command's cycle
// and fields at accept time; a negedge monitor pops and compares.
module tb_cmd_issue;
  localparam int T_RCD = 4, T_RP = 3, T_RAS = 8;

  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_wr = 0;
  logic [15:0] data_i = 0;
  logic [6:0]  idx_i = 0;
  logic [15:0] row_i = 0;
  logic [9:0]  col_i = 0;
  logic [1:0]  ba_i = 0, bg_i = 0;
  logic        req_ready, cmd_valid;
  logic [2:0]  cmd_o;
  logic [15:0] cmd_row, cmd_data;
  logic [9:0]  cmd_col;
  logic [1:0]  cmd_ba, cmd_bg;
  logic [6:0]  cmd_idx;

  cmd_issue #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
    .data_i(data_i), .idx_i(idx_i), .row_i(row_i), .col_i(col_i),
    .ba_i(ba_i), .bg_i(bg_i), .req_ready(req_ready), .cmd_valid(cmd_valid),
    .cmd_o(cmd_o), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ba(cmd_ba),
    .cmd_bg(cmd_bg), .cmd_data(cmd_data), .cmd_idx(cmd_idx));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  ba, bg;
    logic [15:0] data;
    logic [6:0]  idx;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] m_open;
  logic [15:0] m_row [16];
  int          m_last_act;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_open = '0;
    for (int i = 0; i < 16; i++) m_row[i] = '0;
    m_last_act = -1000;
  endtask

  task automatic push(input int c, input logic [2:0] cmd);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.row = row_i; e.col = col_i; e.ba = ba_i;
    e.bg = bg_i; e.data = data_i; e.idx = idx_i;
    sb.push_back(e);
  endtask

  // Drive one request; accept edge returned in acc. keep leaves req_valid high.
  task automatic send(input logic wr, input logic [15:0] row, input logic [9:0] col,
                      input logic [1:0] ba, input logic [1:0] bg, input logic [15:0] data,
                      input logic [6:0] idx, input bit keep, input bit no_cas, output int acc);
    int wait_n, c, act_c, pre_c;
    logic [3:0] k;
    @(negedge clk);
    req_wr = wr; row_i = row; col_i = col; ba_i = ba; bg_i = bg; data_i = data;
    idx_i = idx; req_valid = 1;
    wait_n = 0;
    while (!req_ready && wait_n < 100) begin @(negedge clk); wait_n++; end
    if (!req_ready) begin
      check("ready_timeout", 0, 1);
      req_valid = 0; acc = cyc; return;
    end
    c = cyc + 1; acc = c; k = {bg, ba};
    if (m_open[k] && m_row[k] == row) begin
      if (!no_cas) push(c + 2, wr ? 3'd4 : 3'd3);
    end else begin
      if (m_open[k]) begin
        pre_c = (c + 2 > m_last_act + T_RAS) ? c + 2 : m_last_act + T_RAS;
        push(pre_c, 3'd2);
        act_c = pre_c + T_RP;
      end else act_c = c + 2;
      push(act_c, 3'd1);
      if (!no_cas) push(act_c + T_RCD, wr ? 3'd4 : 3'd3);
      m_open[k] = 1; m_row[k] = row; m_last_act = act_c;
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        if (sb.size() == 0) check("extra_cmd", {29'd0, cmd_o}, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("cmd_cycle", cyc, e.cyc);
          check("cmd_code", cmd_o, e.cmd);
          check("cmd_ba", cmd_ba, e.ba);
          check("cmd_bg", cmd_bg, e.bg);
          if (e.cmd == 3'd1) check("cmd_row", cmd_row, e.row);
          if (e.cmd >= 3'd3) begin
            check("cmd_col", cmd_col, e.col);
            check("cmd_idx", cmd_idx, e.idx);
          end
          if (e.cmd == 3'd4) check("cmd_data", cmd_data, e.data);
        end
      end else check("nop_when_idle", cmd_o, 0);
    end
  end

  task automatic check_reset_outputs();
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd_o, 0);
    check("rst_row", cmd_row, 0);
    check("rst_col", cmd_col, 0);
    check("rst_ba", cmd_ba, 0);
    check("rst_bg", cmd_bg, 0);
    check("rst_data", cmd_data, 0);
    check("rst_idx", cmd_idx, 0);
    check("rst_ready", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, n;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1;
    @(negedge clk);
    check("ready_after_release", req_ready, 1);

    // closed bank, then row hit, then conflict with tRAS long satisfied
    send(0, 16'h0010, 10'h005, 2'd2, 2'd1, 16'h0000, 7'd1, 0, 0, acc);
    send(1, 16'h0010, 10'h006, 2'd2, 2'd1, 16'hBEEF, 7'd2, 0, 0, acc);
    repeat (10) @(negedge clk);
    send(0, 16'h0020, 10'h007, 2'd2, 2'd1, 16'h0000, 7'd3, 0, 0, acc);
    // back-to-back conflict: PRE must wait for the tRAS window
    send(0, 16'h0030, 10'h008, 2'd2, 2'd1, 16'h0000, 7'd4, 0, 0, acc);
    // continuous hits with req_valid held; inputs change while not ready
    for (int i = 0; i < 4; i++)
      send(i[0], 16'h0030, 10'(i), 2'd2, 2'd1, 16'(i * 3 + 1), 7'(10 + i), i != 3, 0, acc);
    // same row value in a different bank is still a closed bank
    send(0, 16'h0010, 10'h001, 2'd0, 2'd0, 16'h0000, 7'd20, 0, 0, acc);

    // reset while in WAIT_RCD: ACT only, CAS must never appear
    send(0, 16'h0040, 10'h002, 2'd3, 2'd3, 16'h0000, 7'd21, 0, 1, acc);
    while (cyc < acc + 3) @(negedge clk);
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    check_reset_outputs();
    model_reset();
    sb.delete();
    rst_n = 1;
    @(negedge clk);
    check("ready_after_abort", req_ready, 1);
    send(0, 16'h0040, 10'h003, 2'd3, 2'd3, 16'h0000, 7'd22, 0, 0, acc);
    send(1, 16'h0030, 10'h004, 2'd2, 2'd1, 16'h1234, 7'd23, 0, 0, acc);

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("scoreboard_drained", sb.size(), 0);
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
